rx_deser: RTL

RX_DESER -- requirements
Module: rx_deser

---
 rtl/rx_deser_if.sv | 22 ++
 rtl/rx_deser.sv | 77 +++++++
 2 files changed

// File: rtl/rx_deser_if.sv
// Serial receiver bundle: line input, byte handshake and status pulses.
interface rx_deser_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxin;
  logic [DATA_BITS-1:0] rdata;
  logic                 rvalid;
  logic                 rready;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  rxin, rready,
    output rdata, rvalid, busy, frame_err, overrun
  );

  modport slave (
    output rxin, rready,
    input  rdata, rvalid, busy, frame_err, overrun
  );
endinterface

// File: rtl/rx_deser.sv
// One-sample-per-bit serial deserializer with a single-entry holding
// register, framing-error detection and overrun reporting.
module rx_deser #(
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  rx_deser_if.master bus
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // one spare bit at the bottom so the shift also works for DATA_BITS=1
  logic [DATA_BITS:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      sh            <= '0;
      bus.rdata     <= '0;
      bus.rvalid    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
      if (bus.rvalid && bus.rready)
        bus.rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.rxin) begin
            state    <= DATA;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        DATA: begin
          sh  <= {bus.rxin, sh[DATA_BITS:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DATA_BITS - 1))
            state <= STOP;
        end
        STOP: begin
          bus.busy <= 1'b0;
          if (bus.rxin) begin
            state <= IDLE;
            if (!bus.rvalid || bus.rready) begin
              bus.rdata  <= sh[DATA_BITS:1];
              bus.rvalid <= 1'b1;
            end else begin
              bus.overrun <= 1'b1;
            end
          end else begin
            bus.frame_err <= 1'b1;
            state         <= BRK;
          end
        end
        BRK: begin
          if (bus.rxin)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule
